life_engine: RTL and testbench

- Parametrised Game-of-Life engine for a ROWS x COLS grid (B3/S23 rule).
- Holds the current generation in a register and loads it from a seed.
- Evolves the grid under run/step control, with a programmable generation rate, selectable toroidal or dead boundary, and stable/empty detection.
- Successor to the fixed 8x8 controller; feeds the LED/display driver.

---
 rtl/life_pkg.sv | 16 +
 rtl/life_engine_if.sv | 30 +++
 rtl/life_next_gen.sv | 51 +++++
 rtl/life_engine.sv | 112 +++++++++++
 tb/tb_life_engine.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life engine.
//   state_t : engine control state (IDLE / RUN / HALT)
//   idx()   : flat bit index of cell (r,c); r=0 is the top row, c=0 the left column
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  function automatic int idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_engine_if.sv
// Control/status bundle between a host (master) and the life engine (slave).
//   load, seed, run, step, wrap_en : host -> engine
//   grid, gen_count, running,
//   stable, empty                  : engine -> host
interface life_engine_if #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
);
  logic                   load;
  logic [ROWS*COLS-1:0]   seed;
  logic                   run;
  logic                   step;
  logic                   wrap_en;
  logic [ROWS*COLS-1:0]   grid;
  logic [GEN_W-1:0]       gen_count;
  logic                   running;
  logic                   stable;
  logic                   empty;

  modport master (
    output load, seed, run, step, wrap_en,
    input  grid, gen_count, running, stable, empty
  );

  modport slave (
    input  load, seed, run, step, wrap_en,
    output grid, gen_count, running, stable, empty
  );
endinterface

// File: rtl/life_next_gen.sv
// Purely combinational B3/S23 successor of a ROWS x COLS grid.
//   grid    : current generation, cell (r,c) at bit r*COLS+c
//   wrap_en : 1 = toroidal edges, 0 = cells outside the grid are dead
//   next    : successor generation
module life_next_gen
  import life_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic [ROWS*COLS-1:0] grid,
  input  logic                 wrap_en,
  output logic [ROWS*COLS-1:0] next
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [8:0] nb;
      logic [3:0] cnt;

      // Neighbour coordinates are elaboration-time constants; only the
      // "outside the grid" gating depends on wrap_en at run time.
      for (genvar dr = 0; dr < 3; dr++) begin : g_dr
        for (genvar dc = 0; dc < 3; dc++) begin : g_dc
          localparam int  RR_RAW = r + dr - 1;
          localparam int  CC_RAW = c + dc - 1;
          localparam bit  INSIDE = (RR_RAW >= 0) && (RR_RAW < ROWS) &&
                                   (CC_RAW >= 0) && (CC_RAW < COLS);
          localparam int  RR     = (RR_RAW + ROWS) % ROWS;
          localparam int  CC     = (CC_RAW + COLS) % COLS;
          if (dr == 1 && dc == 1) begin : g_self
            assign nb[dr*3+dc] = 1'b0;
          end else begin : g_nbr
            assign nb[dr*3+dc] = grid[idx(RR, CC, COLS)] & (INSIDE | wrap_en);
          end
        end
      end

      // NOTE: combinational blocks assign a default first so no path leaves
      // the variable holding its old value, which would infer a latch.
      always_comb begin
        cnt = '0;
        for (int k = 0; k < 9; k++) cnt = cnt + 4'(nb[k]);
      end

      assign next[idx(r, c, COLS)] = grid[idx(r, c, COLS)] ? (cnt == 4'd2 || cnt == 4'd3)
                                                           : (cnt == 4'd3);
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life engine: holds the current generation and evolves it under
// run/step control with a programmable generation rate.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : life_engine_if slave (load/seed/run/step/wrap_en in;
//                grid/gen_count/running/stable/empty out)
module life_engine
  import life_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int PERIOD = 1,
  parameter int GEN_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  life_engine_if.slave  bus
);

  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  state_t                state;
  logic [ROWS*COLS-1:0]  grid_q;
  logic [ROWS*COLS-1:0]  next_grid;
  logic [GEN_W-1:0]      gen_q;
  logic [GEN_W-1:0]      gen_inc;
  logic [CW-1:0]         rate_cnt;
  logic                  running_q;
  logic                  stable_q;
  logic                  tick;
  logic                  same;

  life_next_gen #(.ROWS(ROWS), .COLS(COLS)) u_next (
    .grid    (grid_q),
    .wrap_en (bus.wrap_en),
    .next    (next_grid)
  );

  assign tick    = (rate_cnt == LAST);
  assign same    = (next_grid == grid_q);
  // Saturating increment: the counter sticks at all-ones.
  assign gen_inc = (gen_q == '1) ? gen_q : gen_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      rate_cnt  <= '0;
      running_q <= 1'b0;
      stable_q  <= 1'b0;
    end else if (bus.load) begin
      state     <= IDLE;
      grid_q    <= bus.seed;
      gen_q     <= '0;
      rate_cnt  <= '0;
      running_q <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.run) begin
            state     <= RUN;
            running_q <= 1'b1;
            rate_cnt  <= '0;
          end else if (bus.step) begin
            grid_q   <= next_grid;
            gen_q    <= gen_inc;
            stable_q <= same;
          end
        end
        RUN: begin
          if (!bus.run) begin
            state     <= IDLE;
            running_q <= 1'b0;
            rate_cnt  <= '0;
          end else begin
            rate_cnt <= tick ? '0 : rate_cnt + 1'b1;
            if (tick) begin
              if (same) begin
                // Nothing would change: freeze and report a fixed point.
                stable_q  <= 1'b1;
                state     <= HALT;
                running_q <= 1'b0;
              end else begin
                grid_q   <= next_grid;
                gen_q    <= gen_inc;
                stable_q <= 1'b0;
              end
            end
          end
        end
        HALT: begin
          if (!bus.run) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grid      = grid_q;
  assign bus.gen_count = gen_q;
  assign bus.running   = running_q;
  assign bus.stable    = stable_q;
  assign bus.empty     = (grid_q == '0);

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine. Three instances share clk/reset:
//   u_a : 8x8, PERIOD=1, GEN_W=16  (step, still life, glider, load, async reset)
//   u_b : 8x8, PERIOD=4, GEN_W=16  (rate divider)
//   u_c : 5x5, PERIOD=1, GEN_W=4   (counter saturation on a torus blinker)
// A 3x3 torus has no oscillator (every cell neighbours all eight others), so the
// saturation run uses a blinker on a 5x5 torus instead.
module tb_life_engine;
  import life_pkg::*;

  // 8x8 patterns, bit = r*8+c
  localparam logic [63:0] BLINK_H = (64'd1 << 17) | (64'd1 << 18) | (64'd1 << 19);
  localparam logic [63:0] BLINK_V = (64'd1 << 10) | (64'd1 << 18) | (64'd1 << 26);
  localparam logic [63:0] BLOCK   = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36);
  localparam logic [63:0] GLIDER  = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                    (64'd1 << 17) | (64'd1 << 18);
  // With dead edges the glider reaches the bottom-right corner at gen 20 and
  // collapses into a block at (6..7,6..7) by gen 23; gen 24 is a fixed point.
  localparam logic [63:0] CORNER  = (64'd1 << 54) | (64'd1 << 55) | (64'd1 << 62) | (64'd1 << 63);
  // 5x5 patterns, bit = r*5+c
  localparam logic [24:0] C_BLINK_H = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  life_engine_if #(.ROWS(8), .COLS(8), .GEN_W(16)) bus_a ();
  life_engine_if #(.ROWS(8), .COLS(8), .GEN_W(16)) bus_b ();
  life_engine_if #(.ROWS(5), .COLS(5), .GEN_W(4))  bus_c ();

  life_engine #(.ROWS(8), .COLS(8), .PERIOD(1), .GEN_W(16)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
  life_engine #(.ROWS(8), .COLS(8), .PERIOD(4), .GEN_W(16)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
  life_engine #(.ROWS(5), .COLS(5), .PERIOD(1), .GEN_W(4))  u_c (.clk(clk), .reset(reset), .bus(bus_c));

  // Advance n rising edges and return on the following falling edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus_a.grid !== 64'd0) begin errors++; $display("FAIL reset_grid: got %h want 0", bus_a.grid); end
    checks++; if (bus_a.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus_a.empty); end
    checks++; if (bus_a.gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen: got %0d want 0", bus_a.gen_count); end
    checks++; if (bus_a.running !== 1'b0 || bus_a.stable !== 1'b0) begin errors++; $display("FAIL reset_flags: running=%b stable=%b want 0 0", bus_a.running, bus_a.stable); end
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_blinker_step;
    bus_a.wrap_en = 1'b0;
    bus_a.seed = BLINK_H; bus_a.load = 1'b1; cycles(1); bus_a.load = 1'b0;
    checks++; if (bus_a.grid !== BLINK_H || bus_a.gen_count !== 16'd0) begin errors++; $display("FAIL blink_load: grid=%h gen=%0d want %h 0", bus_a.grid, bus_a.gen_count, BLINK_H); end
    bus_a.step = 1'b1; cycles(1); bus_a.step = 1'b0;
    checks++; if (bus_a.grid !== BLINK_V) begin errors++; $display("FAIL blink_step1_grid: got %h want %h", bus_a.grid, BLINK_V); end
    checks++; if (bus_a.gen_count !== 16'd1 || bus_a.stable !== 1'b0) begin errors++; $display("FAIL blink_step1_status: gen=%0d stable=%b want 1 0", bus_a.gen_count, bus_a.stable); end
    cycles(1);
    checks++; if (bus_a.gen_count !== 16'd1) begin errors++; $display("FAIL blink_idle_hold: gen=%0d want 1", bus_a.gen_count); end
    bus_a.step = 1'b1; cycles(1); bus_a.step = 1'b0;
    checks++; if (bus_a.grid !== BLINK_H || bus_a.gen_count !== 16'd2) begin errors++; $display("FAIL blink_step2: grid=%h gen=%0d want %h 2", bus_a.grid, bus_a.gen_count, BLINK_H); end
  endtask

  task automatic test_still_life;
    bus_a.seed = BLOCK; bus_a.load = 1'b1; cycles(1); bus_a.load = 1'b0;
    bus_a.run = 1'b1; cycles(1);
    checks++; if (bus_a.running !== 1'b1 || bus_a.gen_count !== 16'd0) begin errors++; $display("FAIL still_enter_run: running=%b gen=%0d want 1 0", bus_a.running, bus_a.gen_count); end
    cycles(1);
    checks++; if (bus_a.running !== 1'b0 || bus_a.stable !== 1'b1) begin errors++; $display("FAIL still_halt: running=%b stable=%b want 0 1", bus_a.running, bus_a.stable); end
    checks++; if (bus_a.grid !== BLOCK || bus_a.gen_count !== 16'd0) begin errors++; $display("FAIL still_frozen: grid=%h gen=%0d want %h 0", bus_a.grid, bus_a.gen_count, BLOCK); end
    bus_a.run = 1'b0; cycles(1);
  endtask

  task automatic test_glider_wrap;
    bus_a.wrap_en = 1'b1;
    bus_a.seed = GLIDER; bus_a.load = 1'b1; cycles(1); bus_a.load = 1'b0;
    bus_a.run = 1'b1; cycles(33);
    checks++; if (bus_a.running !== 1'b1 || bus_a.gen_count !== 16'd32) begin errors++; $display("FAIL glider_wrap_run: running=%b gen=%0d want 1 32", bus_a.running, bus_a.gen_count); end
    bus_a.run = 1'b0; cycles(1);
    checks++; if (bus_a.grid !== GLIDER || bus_a.gen_count !== 16'd32) begin errors++; $display("FAIL glider_wrap_return: grid=%h gen=%0d want %h 32", bus_a.grid, bus_a.gen_count, GLIDER); end
    checks++; if (bus_a.running !== 1'b0) begin errors++; $display("FAIL glider_wrap_idle: running=%b want 0", bus_a.running); end
  endtask

  task automatic test_glider_dead;
    int n = 0;
    bus_a.wrap_en = 1'b0;
    bus_a.seed = GLIDER; bus_a.load = 1'b1; cycles(1); bus_a.load = 1'b0;
    bus_a.run = 1'b1; cycles(1);
    while (bus_a.running === 1'b1 && n < 45) begin cycles(1); n++; end
    checks++; if (bus_a.running !== 1'b0) begin errors++; $display("FAIL glider_dead_timeout: running=%b after %0d cycles want 0", bus_a.running, n); end
    checks++; if (bus_a.gen_count !== 16'd23 || bus_a.grid !== CORNER) begin errors++; $display("FAIL glider_dead_final: gen=%0d grid=%h want 23 %h", bus_a.gen_count, bus_a.grid, CORNER); end
    checks++; if (bus_a.stable !== 1'b1 || bus_a.empty !== 1'b0) begin errors++; $display("FAIL glider_dead_flags: stable=%b empty=%b want 1 0", bus_a.stable, bus_a.empty); end
    bus_a.run = 1'b0; cycles(1);
  endtask

  task automatic test_load_during_run;
    bus_a.seed = BLINK_H; bus_a.load = 1'b1; cycles(1); bus_a.load = 1'b0;
    checks++; if (bus_a.stable !== 1'b0) begin errors++; $display("FAIL load_clears_stable: got %b want 0", bus_a.stable); end
    bus_a.run = 1'b1; cycles(4);
    checks++; if (bus_a.grid !== BLINK_V || bus_a.gen_count !== 16'd3) begin errors++; $display("FAIL ldrun_pre: grid=%h gen=%0d want %h 3", bus_a.grid, bus_a.gen_count, BLINK_V); end
    bus_a.seed = BLOCK; bus_a.load = 1'b1; cycles(1); bus_a.load = 1'b0;
    checks++; if (bus_a.grid !== BLOCK || bus_a.gen_count !== 16'd0) begin errors++; $display("FAIL ldrun_grid: grid=%h gen=%0d want %h 0", bus_a.grid, bus_a.gen_count, BLOCK); end
    checks++; if (bus_a.running !== 1'b0 || bus_a.stable !== 1'b0) begin errors++; $display("FAIL ldrun_flags: running=%b stable=%b want 0 0", bus_a.running, bus_a.stable); end
    cycles(1);
    checks++; if (bus_a.running !== 1'b1 || bus_a.grid !== BLOCK) begin errors++; $display("FAIL ldrun_rerun: running=%b grid=%h want 1 %h", bus_a.running, bus_a.grid, BLOCK); end
    bus_a.run = 1'b0; cycles(1);
  endtask

  task automatic test_rate_divider;
    bus_b.wrap_en = 1'b0;
    bus_b.seed = BLINK_H; bus_b.load = 1'b1; cycles(1); bus_b.load = 1'b0;
    bus_b.run = 1'b1; cycles(4);
    checks++; if (bus_b.gen_count !== 16'd0 || bus_b.grid !== BLINK_H || bus_b.running !== 1'b1) begin errors++; $display("FAIL rate_pre_tick: gen=%0d grid=%h running=%b want 0 %h 1", bus_b.gen_count, bus_b.grid, bus_b.running, BLINK_H); end
    cycles(1);
    checks++; if (bus_b.gen_count !== 16'd1 || bus_b.grid !== BLINK_V) begin errors++; $display("FAIL rate_first_tick: gen=%0d grid=%h want 1 %h", bus_b.gen_count, bus_b.grid, BLINK_V); end
    cycles(8);
    bus_b.run = 1'b0; cycles(1);
    checks++; if (bus_b.gen_count !== 16'd3 || bus_b.grid !== BLINK_V || bus_b.running !== 1'b0) begin errors++; $display("FAIL rate_three_gens: gen=%0d grid=%h running=%b want 3 %h 0", bus_b.gen_count, bus_b.grid, bus_b.running, BLINK_V); end
    // Second burst: run falls right before an edge where the rate counter ticks.
    bus_b.run = 1'b1; cycles(8);
    checks++; if (bus_b.gen_count !== 16'd4) begin errors++; $display("FAIL rate_burst2: gen=%0d want 4", bus_b.gen_count); end
    bus_b.run = 1'b0; cycles(1);
    checks++; if (bus_b.gen_count !== 16'd4 || bus_b.grid !== BLINK_H) begin errors++; $display("FAIL rate_stop_on_tick: gen=%0d grid=%h want 4 %h", bus_b.gen_count, bus_b.grid, BLINK_H); end
  endtask

  task automatic test_saturation;
    bus_c.wrap_en = 1'b1;
    bus_c.seed = C_BLINK_H; bus_c.load = 1'b1; cycles(1); bus_c.load = 1'b0;
    bus_c.run = 1'b1; cycles(15);
    checks++; if (bus_c.gen_count !== 4'd14) begin errors++; $display("FAIL sat_gen14: got %0d want 14", bus_c.gen_count); end
    cycles(1);
    checks++; if (bus_c.gen_count !== 4'd15) begin errors++; $display("FAIL sat_gen15: got %0d want 15", bus_c.gen_count); end
    cycles(5);
    checks++; if (bus_c.gen_count !== 4'd15 || bus_c.grid !== C_BLINK_H || bus_c.running !== 1'b1) begin errors++; $display("FAIL sat_hold: gen=%0d grid=%h running=%b want 15 %h 1", bus_c.gen_count, bus_c.grid, bus_c.running, C_BLINK_H); end
    bus_c.run = 1'b0; cycles(1);
  endtask

  task automatic test_async_reset;
    bus_a.wrap_en = 1'b0;
    bus_a.seed = BLINK_H; bus_a.load = 1'b1; cycles(1); bus_a.load = 1'b0;
    bus_a.run = 1'b1; cycles(3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus_a.grid !== 64'd0 || bus_a.empty !== 1'b1) begin errors++; $display("FAIL areset_grid: grid=%h empty=%b want 0 1", bus_a.grid, bus_a.empty); end
    checks++; if (bus_a.gen_count !== 16'd0 || bus_a.running !== 1'b0) begin errors++; $display("FAIL areset_state: gen=%0d running=%b want 0 0", bus_a.gen_count, bus_a.running); end
    @(negedge clk);
    bus_a.run = 1'b0; reset = 1'b0;
    cycles(1);
    checks++; if (bus_a.grid !== 64'd0 || bus_a.running !== 1'b0) begin errors++; $display("FAIL areset_release: grid=%h running=%b want 0 0", bus_a.grid, bus_a.running); end
  endtask

  initial begin
    reset = 1'b1;
    bus_a.load = 1'b0; bus_a.seed = '0; bus_a.run = 1'b0; bus_a.step = 1'b0; bus_a.wrap_en = 1'b0;
    bus_b.load = 1'b0; bus_b.seed = '0; bus_b.run = 1'b0; bus_b.step = 1'b0; bus_b.wrap_en = 1'b0;
    bus_c.load = 1'b0; bus_c.seed = '0; bus_c.run = 1'b0; bus_c.step = 1'b0; bus_c.wrap_en = 1'b0;
    test_reset();
    test_blinker_step();
    test_still_life();
    test_glider_wrap();
    test_glider_dead();
    test_load_during_run();
    test_rate_divider();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
